srv_line_fill: RTL and testbench
================================

SRV_LINE_FILL -- requirements
Module: srv_line_fill

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per cache line (line = 128 bits).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ext_req_i  in  1  cache line-fill request, sampled only in IDLE.
- ext_addr_i  in  ADDR_W  miss byte address; low log2(LINE_WORDS*4) bits ignored.
- ext_rsp_o  out  1  one-cycle pulse: line complete.
- ext_data_o  out  32*LINE_WORDS  assembled line; word k at bits [32k+:32]; valid while ext_rsp_o=1 and held until the next fill starts.
- busy_o  out  1  fill in progress (state != IDLE).
- mem_req_o  out  1  word read request to memory.
- mem_addr_o  out  ADDR_W  word byte address, bits [1:0]=0.
- mem_gnt_i  in  1  memory accepts a request this cycle (mem_req_o & mem_gnt_i).
- mem_rvalid_i  in  1  read data valid; in-order, one per granted request.
- mem_rdata_i  in  32  read data.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, DRAIN, RESP.
REQ-005 In IDLE with ext_req_i=1, the block SHALL latch line base = ext_addr_i with offset bits cleared, clear both counters and enter ISSUE next cycle.
REQ-006 ext_req_i SHALL be ignored outside IDLE, with no queuing.
REQ-007 In ISSUE, mem_req_o SHALL be 1 and mem_addr_o SHALL equal base + 4*issue_cnt, ascending from word 0.
- issue_cnt SHALL increment on each grant.
- On the grant with issue_cnt = LINE_WORDS-1, the FSM SHALL go to DRAIN, or straight to RESP if that grant's cycle also captures the last beat (not possible when rvalid lags gnt by at least one cycle).
REQ-008 mem_req_o SHALL be 0 in IDLE, DRAIN and RESP, and mem_addr_o SHALL be unchanged when mem_req_o=0.
REQ-009 Beat capture:
- Each mem_rvalid_i in ISSUE or DRAIN SHALL write mem_rdata_i into word rsp_cnt of the line register and increment rsp_cnt.
- rvalid in the same cycle as a grant SHALL be counted independently.
REQ-010 When rsp_cnt reaches LINE_WORDS, the FSM SHALL enter RESP.
- RESP SHALL last exactly one cycle with ext_rsp_o=1, then return to IDLE.
- A new ext_req_i SHALL be accepted no earlier than the IDLE cycle after RESP.
REQ-011 mem_rvalid_i in IDLE or RESP, or when rsp_cnt = issue_cnt, SHALL be ignored and SHALL corrupt no state.
REQ-012 Counter widths:
- issue_cnt and rsp_cnt SHALL be $clog2(LINE_WORDS)+1 bits and SHALL NOT wrap within a fill.
- Address arithmetic SHALL be ADDR_W bits, modulo 2^ADDR_W; a line at the top of the address space SHALL NOT carry into the base.
REQ-013 Minimum latency, with mem_gnt_i=1 and rvalid one cycle after grant:
- req in cycle 0.
- mem_req_o in cycles 1-4.
- rvalid in cycles 2-5.
- ext_rsp_o in cycle 6.
REQ-014 Stalls (mem_gnt_i=0) SHALL hold mem_req_o and mem_addr_o stable until granted.

Reset
REQ-015 On rst_n=0, asynchronously:
- state SHALL be IDLE.
- issue_cnt and rsp_cnt SHALL be 0.
- ext_rsp_o, mem_req_o and busy_o SHALL be 0.
- mem_addr_o and the line register SHALL be 0.
REQ-016 Reset mid-fill SHALL abandon the fill without producing ext_rsp_o; memory shares rst_n, so no stale responses are expected.

Structure
REQ-017 The shared package srv_pkg SHALL hold the LINE_WORDS default, the line width constant (32*LINE_WORDS) and the FSM state enum (line_fill_state_t).
REQ-018 No sub-module SHALL be used; counters, FSM and line register SHALL be inline in srv_line_fill.

Verification
REQ-019 Back-to-back zero-wait: gnt=1, rvalid 1 cycle after grant, req addr 0x0000_1238 -> mem_addr_o 0x1230, 0x1234, 0x1238, 0x123C in cycles 1-4; ext_rsp_o in cycle 6; ext_data_o = {D3,D2,D1,D0}.
REQ-020 Grant stalls: gnt low for 3 cycles on word 2 -> mem_addr_o holds 0x...8 stable; line correct; ext_rsp_o exactly once.
REQ-021 Response lag: all 4 grants, then rvalids 5-8 cycles later -> FSM stays in DRAIN with mem_req_o=0; ext_rsp_o one cycle after the 4th beat.
REQ-022 Ignored inputs: ext_req_i held high through the whole fill, plus a spurious rvalid in IDLE -> only one fill per IDLE acceptance; line register unchanged by the spurious beat.
REQ-023 Reset mid-fill: rst_n low after 2 beats -> all outputs 0 immediately; no ext_rsp_o; a following req at 0xFFFF_FFF0 fetches 0xFFFF_FFF0..0xFFFF_FFFC with no wrap into the base.

Source files
------------

// File: rtl/srv_pkg.sv
// Shared definitions for the line-fill engine: default line geometry and FSM states.
package srv_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int LINE_BITS_DEF  = 32 * LINE_WORDS_DEF;

  typedef enum logic [1:0] {
    LF_IDLE  = 2'd0,
    LF_ISSUE = 2'd1,
    LF_DRAIN = 2'd2,
    LF_RESP  = 2'd3
  } line_fill_state_t;

  // Width in bits of a line holding the given number of 32-bit words.
  function automatic int line_bits(input int words);
    return 32 * words;
  endfunction

endpackage

// File: rtl/srv_line_fill.sv
// Cache line-fill engine: fetches one line as LINE_WORDS sequential word reads,
// assembles the beats in order and pulses ext_rsp_o once the line is complete.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// LF_IDLE  | waiting for ext_req_i; line register holds the last line
// LF_ISSUE | mem_req_o high, one word address per grant, beats captured
// LF_DRAIN | all requests granted, waiting for outstanding beats
// LF_RESP  | single cycle, ext_rsp_o high, line valid on ext_data_o
module srv_line_fill
  import srv_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ext_req_i,
  input  logic [ADDR_W-1:0]       ext_addr_i,
  output logic                    ext_rsp_o,
  output logic [32*LINE_WORDS-1:0] ext_data_o,
  output logic                    busy_o,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i
);

  localparam int LINE_BITS = line_bits(LINE_WORDS);
  localparam int CNT_W     = $clog2(LINE_WORDS) + 1;
  localparam int OFF_W     = $clog2(LINE_WORDS * 4);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);

  line_fill_state_t       state_q, state_d;
  logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]       rsp_cnt_q, rsp_cnt_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]   line_q, line_d;

  logic grant;
  logic beat;
  logic unused_addr_bits;

  // Offset bits of the request address never reach the datapath.
  assign unused_addr_bits = ^ext_addr_i[OFF_W-1:0];

  assign grant = (state_q == LF_ISSUE) & mem_gnt_i;
  // A beat only counts while a granted request is still outstanding.
  assign beat  = mem_rvalid_i
               & ((state_q == LF_ISSUE) | (state_q == LF_DRAIN))
               & (rsp_cnt_q != issue_cnt_q);

  // Next-state, counter, address and line-register update.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    mem_addr_d  = mem_addr_q;
    line_d      = line_q;

    case (state_q)
      LF_IDLE: begin
        if (ext_req_i) begin
          state_d     = LF_ISSUE;
          issue_cnt_d = '0;
          rsp_cnt_d   = '0;
          mem_addr_d  = {ext_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      LF_ISSUE: begin
        if (grant) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          // The address stays on the last word once every request is out,
          // so a line at the top of the space never carries past it.
          if (issue_cnt_q == LAST_IDX) begin
            state_d = LF_DRAIN;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(4);
          end
        end
      end
      LF_DRAIN: begin
      end
      LF_RESP: begin
        state_d = LF_IDLE;
      end
      default: begin
        state_d = LF_IDLE;
      end
    endcase

    if (beat) begin
      rsp_cnt_d = rsp_cnt_q + 1'b1;
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (rsp_cnt_q == CNT_W'(k)) begin
          line_d[32*k +: 32] = mem_rdata_i;
        end
      end
    end

    if (((state_q == LF_ISSUE) || (state_q == LF_DRAIN)) && (rsp_cnt_d == FULL_CNT)) begin
      state_d = LF_RESP;
    end
  end

  // State, counters, address and line register with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LF_IDLE;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      mem_addr_q  <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      mem_addr_q  <= mem_addr_d;
      line_q      <= line_d;
    end
  end

  assign mem_req_o  = (state_q == LF_ISSUE);
  assign busy_o     = (state_q != LF_IDLE);
  assign ext_rsp_o  = (state_q == LF_RESP);
  assign mem_addr_o = mem_addr_q;
  assign ext_data_o = line_q;

endmodule

// File: tb/tb_srv_line_fill.sv
// Self-checking bench for srv_line_fill: directed fill table, hand-written
// corner sequences and randomized fills against a transaction-level model.
module tb_srv_line_fill;

  localparam int LW = 4;

  logic          clk;
  logic          rst_n;
  logic          ext_req_i;
  logic [31:0]   ext_addr_i;
  logic          ext_rsp_o;
  logic [127:0]  ext_data_o;
  logic          busy_o;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;

  srv_line_fill #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ext_req_i    (ext_req_i),
    .ext_addr_i   (ext_addr_i),
    .ext_rsp_o    (ext_rsp_o),
    .ext_data_o   (ext_data_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          gnt_prob;
    int          lat_min;
    int          lat_max;
    int          stall_word;
    int          stall_len;
    bit          hold_req;
    int          spur_prob;
    logic [31:0] exp_base;
    int          exp_lat;
  } vec_t;

  vec_t tbl[5];

  int errors = 0;
  int checks = 0;

  // transaction-level model of the fill in progress
  bit          m_active;
  int          m_grants;
  int          m_beats;
  logic [31:0] m_base;
  logic [127:0] m_last_line;
  int          cyc;

  // memory responder: in-order pending beats
  int          q_due[$];
  logic [31:0] q_data[$];

  // stimulus knobs
  int          k_gnt_prob;
  int          k_lat_min;
  int          k_lat_max;
  int          k_stall_word;
  int          k_stall_left;
  int          k_spur_prob;
  bit          k_req;
  logic [31:0] k_addr;

  // per-fill observations
  int          rsp_seen;
  int          rsp_cyc;
  logic [31:0] first_addr;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: called at a falling edge, checks outputs, drives inputs,
  // advances the model across the next rising edge, returns at the next falling edge.
  task automatic cycle();
    bit           exp_req;
    bit           exp_rsp;
    bit           gnt;
    bit           rv;
    logic [127:0] exp_line;
    int           lat;

    exp_req = m_active && (m_grants < LW);
    exp_rsp = m_active && (m_beats == LW);
    check("busy", 128'(busy_o), 128'(m_active));
    check("mem_req", 128'(mem_req_o), 128'(exp_req));
    if (exp_req) check("mem_addr", 128'(mem_addr_o), 128'(m_base + 32'(4 * m_grants)));
    check("ext_rsp", 128'(ext_rsp_o), 128'(exp_rsp));
    if (exp_rsp) begin
      for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = mem_fn(m_base + 32'(4 * k));
      check("line", ext_data_o, exp_line);
      m_last_line = exp_line;
      rsp_seen++;
      rsp_cyc = cyc;
    end else if (!m_active) begin
      check("line_hold", ext_data_o, m_last_line);
    end

    ext_req_i  = k_req;
    ext_addr_i = k_req ? k_addr : $urandom;
    if (exp_req && (m_grants == k_stall_word) && (k_stall_left > 0)) begin
      gnt = 1'b0;
      k_stall_left--;
    end else begin
      gnt = int'($urandom_range(99, 0)) < k_gnt_prob;
    end
    mem_gnt_i = gnt;

    rv = 1'b0;
    mem_rdata_i = $urandom;
    if ((q_due.size() > 0) && (q_due[0] <= cyc)) begin
      rv = 1'b1;
      mem_rdata_i = q_data.pop_front();
      void'(q_due.pop_front());
    end else if ((!m_active || exp_rsp || (m_beats == m_grants)) &&
                 (int'($urandom_range(99, 0)) < k_spur_prob)) begin
      rv = 1'b1;
    end
    mem_rvalid_i = rv;

    if (m_active && !exp_rsp && rv && (m_beats < m_grants)) m_beats++;
    if (exp_req && gnt) begin
      if (m_grants == 0) first_addr = mem_addr_o;
      last_addr = mem_addr_o;
      lat = int'($urandom_range(k_lat_max, k_lat_min));
      q_due.push_back(cyc + lat);
      q_data.push_back(mem_fn(mem_addr_o));
      m_grants++;
    end
    if (exp_rsp) begin
      m_active = 1'b0;
    end else if (!m_active && ext_req_i) begin
      m_active = 1'b1;
      m_base   = ext_addr_i & 32'hFFFF_FFF0;
      m_grants = 0;
      m_beats  = 0;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_fill(input vec_t r);
    int n;
    int start;
    k_gnt_prob   = r.gnt_prob;
    k_lat_min    = r.lat_min;
    k_lat_max    = r.lat_max;
    k_stall_word = r.stall_word;
    k_stall_left = r.stall_len;
    k_spur_prob  = r.spur_prob;
    k_addr       = r.addr;
    k_req        = 1'b1;
    rsp_seen     = 0;
    first_addr   = 'x;
    last_addr    = 'x;
    start        = cyc;
    n = 0;
    while ((rsp_seen == 0) && (n < 100)) begin
      cycle();
      k_req = r.hold_req;
      n++;
    end
    k_req = 1'b0;
    check("fill_rsp_count", 128'(rsp_seen), 128'(1));
    check("first_addr", 128'(first_addr), 128'(r.exp_base));
    check("last_addr", 128'(last_addr), 128'(r.exp_base + 32'd12));
    if (r.exp_lat >= 0) check("latency", 128'(rsp_cyc - start), 128'(r.exp_lat));
    cycle();
  endtask

  initial begin
    vec_t rv;
    int   n;
    logic [31:0] a;

    tbl[0] = '{32'h0000_1238, 100, 1, 1, -1, 0, 1'b0, 0,  32'h0000_1230, 6};
    tbl[1] = '{32'h0000_2004, 100, 1, 1,  2, 3, 1'b0, 0,  32'h0000_2000, 9};
    tbl[2] = '{32'h0000_300C, 100, 5, 5, -1, 0, 1'b0, 0,  32'h0000_3000, 10};
    tbl[3] = '{32'hFFFF_FFF0, 100, 1, 1, -1, 0, 1'b0, 0,  32'hFFFF_FFF0, 6};
    tbl[4] = '{32'h0000_4000, 100, 2, 2, -1, 0, 1'b1, 30, 32'h0000_4000, 7};

    cyc = 0;
    m_active = 1'b0; m_grants = 0; m_beats = 0; m_base = '0; m_last_line = '0;
    k_gnt_prob = 100; k_lat_min = 1; k_lat_max = 1; k_stall_word = -1;
    k_stall_left = 0; k_spur_prob = 0; k_req = 1'b0; k_addr = '0;
    rst_n = 1'b0; ext_req_i = 1'b0; ext_addr_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_mem_req", 128'(mem_req_o), 128'(0));
    check("rst_ext_rsp", 128'(ext_rsp_o), 128'(0));
    check("rst_mem_addr", 128'(mem_addr_o), 128'(0));
    check("rst_line", ext_data_o, 128'(0));
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 5; i++) do_fill(tbl[i]);

    // spurious beats while idle must leave the line untouched
    k_spur_prob = 100;
    repeat (3) cycle();
    k_spur_prob = 0;

    // reset after two beats abandons the fill
    k_gnt_prob = 100; k_lat_min = 1; k_lat_max = 1; k_stall_word = -1;
    k_addr = 32'h0000_5000; k_req = 1'b1; rsp_seen = 0;
    cycle();
    k_req = 1'b0;
    n = 0;
    while ((m_beats < 2) && (n < 20)) begin
      cycle();
      n++;
    end
    check("rst_setup_beats", 128'(m_beats), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy_o), 128'(0));
    check("midrst_mem_req", 128'(mem_req_o), 128'(0));
    check("midrst_ext_rsp", 128'(ext_rsp_o), 128'(0));
    check("midrst_mem_addr", 128'(mem_addr_o), 128'(0));
    check("midrst_line", ext_data_o, 128'(0));
    m_active = 1'b0; m_grants = 0; m_beats = 0; m_last_line = '0;
    q_due.delete(); q_data.delete();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    check("midrst_no_rsp", 128'(rsp_seen), 128'(0));
    do_fill(tbl[3]);

    // randomized fills with grant stalls, variable latency and ignorable beats
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      rv.addr       = a;
      rv.gnt_prob   = 70;
      rv.lat_min    = 1;
      rv.lat_max    = 4;
      rv.stall_word = -1;
      rv.stall_len  = 0;
      rv.hold_req   = ($urandom_range(3, 0) == 0);
      rv.spur_prob  = 25;
      rv.exp_base   = a & 32'hFFFF_FFF0;
      rv.exp_lat    = -1;
      do_fill(rv);
      k_spur_prob = 25;
      repeat ($urandom_range(3, 0)) cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
